systolic_tile_sequencer: RTL

SYSTOLIC_TILE_SEQUENCER -- requirements
Module: systolic_tile_sequencer

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/skew_delay_line.sv | 62 ++++++
 rtl/systolic_tile_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic tile sequencer: lane geometry, the
// sequencer state encoding and the per-lane skew depth helper.
// Optional build feature: SYSTOLIC_SEQ_PERF_CNT_EN (stall counter output).
package systolic_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned DATA_W = LANES * LANE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Lane k sits behind (LANES - k) delay stages after the common input
    // stage, so the highest lane leaves first and lane 0 leaves last.
    function automatic int unsigned lane_depth(input int unsigned lane);
        return LANES - lane;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// One lane of the input skew: a DEPTH-stage shift register carrying the lane
// byte and its valid bit, with a synchronous clear used when a tile is
// cancelled. Output is taken straight from the last register stage.
module skew_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 8
) (
    input  logic         axi_clk,
    input  logic         axi_rst_n,
    input  logic         clr,
    input  logic [W-1:0] din,
    input  logic         vin,
    output logic [W-1:0] dout,
    output logic         vout
);

    logic [DEPTH*W-1:0] data_q;
    logic [DEPTH*W-1:0] data_d;
    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   valid_d;
    logic [DEPTH*W-1:0] data_shift_s;
    logic [DEPTH-1:0]   valid_shift_s;

    // Newest entry enters at the bottom; a single-stage line has nothing to shift.
    generate
        if (DEPTH == 1) begin : g_single
            assign data_shift_s  = din;
            assign valid_shift_s = vin;
        end else begin : g_multi
            assign data_shift_s  = {data_q[(DEPTH-1)*W-1:0], din};
            assign valid_shift_s = {valid_q[DEPTH-2:0], vin};
        end
    endgenerate

    // Next-state: shift one stage per cycle, or wipe the whole line on clear.
    always_comb begin
        data_d  = data_shift_s;
        valid_d = valid_shift_s;
        if (clr) begin
            data_d  = '0;
            valid_d = '0;
        end else begin
            data_d  = data_shift_s;
            valid_d = valid_shift_s;
        end
    end

    // Delay-line registers with asynchronous reset.
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign dout = data_q[DEPTH*W-1 -: W];
    assign vout = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Systolic tile sequencer: accepts tile_len 32-bit beats over AXI4-Stream,
// skews the four byte lanes into the array (lane 3 first, lane 0 last),
// drains for DRAIN_CYCLES cycles and pulses done. abort cancels a tile and
// flushes the skew pipeline. Define SYSTOLIC_SEQ_PERF_CNT_EN to add the
// stall_cnt output counting LOAD cycles without s_axis_valid.
module systolic_tile_sequencer
    import systolic_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 7
) (
    input  logic                axi_clk,
    input  logic                axi_rst_n,
    input  logic                start,
    input  logic [7:0]          tile_len,
    input  logic                abort,
    input  logic                s_axis_valid,
    input  logic [DATA_W-1:0]   s_axis_data,
    output logic                s_axis_ready,
    output logic [DATA_W-1:0]   arr_data,
    output logic [LANES-1:0]    arr_valid,
    output logic                busy,
    output logic                done
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 32'd1);

    seq_state_t          state_q, state_d;
    logic [7:0]          tile_len_q, tile_len_d;
    logic [7:0]          beat_cnt_q, beat_cnt_d;
    logic [7:0]          drain_cnt_q, drain_cnt_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   stage_data_q, stage_data_d;
    logic [LANES-1:0]    stage_valid_q, stage_valid_d;

    logic                hs_s;
    logic                abort_act_s;
    logic                start_acc_s;

    assign hs_s        = ready_q & s_axis_valid;
    assign abort_act_s = abort & ((state_q == ST_LOAD) | (state_q == ST_DRAIN));
    assign start_acc_s = (state_q == ST_IDLE) & start & ~abort;

    // Sequencer next-state, counters and registered-output precomputation.
    always_comb begin
        state_d     = state_q;
        tile_len_d  = tile_len_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_acc_s) begin
                    tile_len_d  = tile_len;
                    beat_cnt_d  = 8'd0;
                    drain_cnt_d = 8'd0;
                    if (tile_len != 8'd0) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    beat_cnt_d = 8'd0;
                end else if (hs_s) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if ((beat_cnt_q + 8'd1) == tile_len_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    drain_cnt_d = 8'd0;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = ST_DONE;
                    drain_cnt_d = 8'd0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_LOAD);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // Common input stage: accepted beat, or a zero bubble when no handshake
    // or when a cancel discards the beat and flushes the pipeline.
    always_comb begin
        stage_data_d  = '0;
        stage_valid_d = '0;
        if (abort_act_s || !hs_s) begin
            stage_data_d  = '0;
            stage_valid_d = '0;
        end else begin
            stage_data_d  = s_axis_data;
            stage_valid_d = {LANES{1'b1}};
        end
    end

    // Sequencer state, counters, output flops and input stage.
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            state_q       <= ST_IDLE;
            tile_len_q    <= 8'd0;
            beat_cnt_q    <= 8'd0;
            drain_cnt_q   <= 8'd0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            stage_data_q  <= '0;
            stage_valid_q <= '0;
        end else begin
            state_q       <= state_d;
            tile_len_q    <= tile_len_d;
            beat_cnt_q    <= beat_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            stage_data_q  <= stage_data_d;
            stage_valid_q <= stage_valid_d;
        end
    end

    assign s_axis_ready = ready_q;
    assign busy         = busy_q;
    assign done         = done_q;

    // Per-lane skew: lane k is delayed (LANES - k) further cycles.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        skew_delay_line #(
            .DEPTH (lane_depth(k)),
            .W     (LANE_W)
        ) u_delay (
            .axi_clk   (axi_clk),
            .axi_rst_n (axi_rst_n),
            .clr       (abort_act_s),
            .din       (stage_data_q[k*LANE_W +: LANE_W]),
            .vin       (stage_valid_q[k]),
            .dout      (arr_data[k*LANE_W +: LANE_W]),
            .vout      (arr_valid[k])
        );
    end

`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Stall counter: LOAD cycles without source data, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_acc_s) begin
            stall_cnt_d = 16'd0;
        end else if ((state_q == ST_LOAD) && !s_axis_valid && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
